gtx_tx_reset_seq: RTL and testbench

Transmitter reset and link-startup sequencer for one GTX lane. It waits for the TX PLL to lock, pulses the GTX TX reset and waits for TXRESETDONE. It then releases the reset of the downstream TX phase-alignment FSM and supervises its SYNC_DONE, with a timeout and a bounded number of retries. State, counters and registered outputs are triple-modular-redundant with majority voting, matching the rest of the link logic.

---
 rtl/gtx_link_pkg.sv | 66 ++++++
 rtl/tmr_vote.sv | 13 +
 rtl/gtx_tx_reset_seq.sv | 154 +++++++++++++++
 tb/tb_gtx_tx_reset_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gtx_link_pkg.sv
// Shared encodings, widths and helpers for the GTX link bring-up logic.
package gtx_link_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK     = 3'd0,
    S_GTX_RESET     = 3'd1,
    S_WAIT_RST_DONE = 3'd2,
    S_START_SYNC    = 3'd3,
    S_WAIT_SYNC     = 3'd4,
    S_LINK_UP       = 3'd5,
    S_FAULT         = 3'd6
  } state_t;

  localparam int LCNT_W      = 16;
  localparam int PCNT_W      = 8;
  localparam int TCNT_W      = 16;
  localparam int RETRY_W     = 4;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic gtx_txreset;
    logic sync_rst;
    logic link_ready;
    logic fault;
  } out_t;

  // Everything that is triplicated lives in one record so the copies stay in step.
  typedef struct packed {
    state_t              state;
    logic [LCNT_W-1:0]   lcnt;
    logic [PCNT_W-1:0]   pcnt;
    logic [TCNT_W-1:0]   tcnt;
    logic [RETRY_W-1:0]  retry;
    out_t                outs;
  } tmr_t;

  function automatic out_t decode_outputs(input state_t s);
    out_t o;
    o = '0;
    case (s)
      S_WAIT_LOCK, S_GTX_RESET: begin
        o.gtx_txreset = 1'b1;
        o.sync_rst    = 1'b1;
      end
      S_WAIT_RST_DONE, S_START_SYNC: o.sync_rst = 1'b1;
      S_LINK_UP: o.link_ready = 1'b1;
      S_FAULT: begin
        o.gtx_txreset = 1'b1;
        o.sync_rst    = 1'b1;
        o.fault       = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  localparam tmr_t TMR_RESET = '{
    state: S_WAIT_LOCK,
    lcnt:  '0,
    pcnt:  '0,
    tcnt:  '0,
    retry: '0,
    outs:  '{gtx_txreset: 1'b1, sync_rst: 1'b1, link_ready: 1'b0, fault: 1'b0}
  };

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter; keep stops synthesis from folding the copies together.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  (* keep = "true" *) output logic [W-1:0] y_o
);

  assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/gtx_tx_reset_seq.sv
// GTX TX reset / phase-alignment startup sequencer for one lane, with triplicated
// state, counters and outputs voted back into a single next-state computation.
module gtx_tx_reset_seq
  import gtx_link_pkg::*;
#(
  parameter int LOCK_WAIT    = 1024,
  parameter int RST_PULSE    = 16,
  parameter int SYNC_TIMEOUT = 40000,
  parameter int MAX_RETRY    = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PLL_LOCK,
  input  logic               TX_RESETDONE,
  input  logic               SYNC_DONE,
  output logic               GTX_TXRESET,
  output logic               SYNC_RST,
  output logic               LINK_READY,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic               FAULT
);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] done_sync_q;
  logic                   lock_s;
  logic                   done_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_sync_q <= '0;
      done_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
      done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], TX_RESETDONE};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign done_s = done_sync_q[SYNC_STAGES-1];

  tmr_t copy0_q, copy1_q, copy2_q;
  tmr_t next_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      copy0_q <= TMR_RESET;
      copy1_q <= TMR_RESET;
      copy2_q <= TMR_RESET;
    end else begin
      copy0_q <= next_d;
      copy1_q <= next_d;
      copy2_q <= next_d;
    end
  end

  logic [2:0]         state_vote;
  state_t             state_v;
  logic [LCNT_W-1:0]  lcnt_v;
  logic [PCNT_W-1:0]  pcnt_v;
  logic [TCNT_W-1:0]  tcnt_v;
  logic [RETRY_W-1:0] retry_v;
  logic [3:0]         outs_vote;
  out_t               outs_v;

  tmr_vote #(.W(3)) u_vote_state (
    .a_i(copy0_q.state), .b_i(copy1_q.state), .c_i(copy2_q.state), .y_o(state_vote));
  tmr_vote #(.W(LCNT_W)) u_vote_lcnt (
    .a_i(copy0_q.lcnt), .b_i(copy1_q.lcnt), .c_i(copy2_q.lcnt), .y_o(lcnt_v));
  tmr_vote #(.W(PCNT_W)) u_vote_pcnt (
    .a_i(copy0_q.pcnt), .b_i(copy1_q.pcnt), .c_i(copy2_q.pcnt), .y_o(pcnt_v));
  tmr_vote #(.W(TCNT_W)) u_vote_tcnt (
    .a_i(copy0_q.tcnt), .b_i(copy1_q.tcnt), .c_i(copy2_q.tcnt), .y_o(tcnt_v));
  tmr_vote #(.W(RETRY_W)) u_vote_retry (
    .a_i(copy0_q.retry), .b_i(copy1_q.retry), .c_i(copy2_q.retry), .y_o(retry_v));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vote_out
      tmr_vote #(.W(1)) u_vote (
        .a_i(copy0_q.outs[gi]), .b_i(copy1_q.outs[gi]), .c_i(copy2_q.outs[gi]),
        .y_o(outs_vote[gi]));
    end
  endgenerate

  assign state_v = state_t'(state_vote);
  assign outs_v  = out_t'(outs_vote);

  state_t             state_d;
  logic [RETRY_W-1:0] retry_d;
  logic [LCNT_W-1:0]  lcnt_d;
  logic [PCNT_W-1:0]  pcnt_d;
  logic [TCNT_W-1:0]  tcnt_d;
  logic               timeout;

  always_comb begin
    state_d = state_v;
    retry_d = retry_v;
    timeout = 1'b0;
    case (state_v)
      S_WAIT_LOCK:
        if (lock_s && lcnt_v == LCNT_W'(LOCK_WAIT - 1)) state_d = S_GTX_RESET;
      S_GTX_RESET:
        if (pcnt_v == PCNT_W'(RST_PULSE - 1)) state_d = S_WAIT_RST_DONE;
      S_WAIT_RST_DONE:
        if (done_s) state_d = S_START_SYNC;
        else if (tcnt_v == TCNT_W'(SYNC_TIMEOUT)) timeout = 1'b1;
      S_START_SYNC:
        state_d = S_WAIT_SYNC;
      S_WAIT_SYNC:
        if (SYNC_DONE) state_d = S_LINK_UP;
        else if (tcnt_v == TCNT_W'(SYNC_TIMEOUT)) timeout = 1'b1;
      S_LINK_UP:
        if (!SYNC_DONE || !done_s) state_d = S_GTX_RESET;
      S_FAULT:
        state_d = S_FAULT;
      default:
        state_d = S_WAIT_LOCK;
    endcase
    // Losing lock overrides everything, including a timeout in the same cycle.
    if (!lock_s && state_v != S_WAIT_LOCK && state_v != S_FAULT) begin
      state_d = S_WAIT_LOCK;
    end else if (timeout) begin
      if (retry_v == RETRY_W'(MAX_RETRY)) begin
        state_d = S_FAULT;
      end else begin
        retry_d = retry_v + 1'b1;
        state_d = S_GTX_RESET;
      end
    end
  end

  assign lcnt_d = (state_v == S_WAIT_LOCK && state_d == S_WAIT_LOCK && lock_s)
                  ? lcnt_v + 1'b1 : '0;
  assign pcnt_d = (state_v == S_GTX_RESET && state_d == S_GTX_RESET)
                  ? pcnt_v + 1'b1 : '0;
  assign tcnt_d = ((state_v == S_WAIT_RST_DONE || state_v == S_WAIT_SYNC) && state_d == state_v)
                  ? tcnt_v + 1'b1 : '0;

  assign next_d = '{
    state: state_d,
    lcnt:  lcnt_d,
    pcnt:  pcnt_d,
    tcnt:  tcnt_d,
    retry: retry_d,
    outs:  decode_outputs(state_d)
  };

  assign GTX_TXRESET = outs_v.gtx_txreset;
  assign SYNC_RST    = outs_v.sync_rst;
  assign LINK_READY  = outs_v.link_ready;
  assign FAULT       = outs_v.fault;
  assign RETRY_CNT   = retry_v;

endmodule

// File: tb/tb_gtx_tx_reset_seq.sv
// Directed bench for gtx_tx_reset_seq: bring-up, lock glitch, timeouts, PLL loss, upsets, async reset.
module tb_gtx_tx_reset_seq;
  import gtx_link_pkg::*;

  localparam int LW = 8;
  localparam int RP = 4;
  localparam int TO = 100;
  localparam int MR = 3;
  localparam int BRINGUP = 2 + LW + RP;

  localparam int SIG_TXRST   = 0;
  localparam int SIG_SYNCRST = 1;
  localparam int SIG_READY   = 2;
  localparam int SIG_FAULT   = 3;
  localparam int SIG_RETRY   = 4;

  logic       CLK;
  logic       RST;
  logic       PLL_LOCK;
  logic       TX_RESETDONE;
  logic       SYNC_DONE;
  logic       GTX_TXRESET;
  logic       SYNC_RST;
  logic       LINK_READY;
  logic [3:0] RETRY_CNT;
  logic       FAULT;

  int   n_checks = 0;
  int   n_errors = 0;
  tmr_t upset;

  gtx_tx_reset_seq #(
    .LOCK_WAIT(LW), .RST_PULSE(RP), .SYNC_TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .CLK(CLK), .RST(RST), .PLL_LOCK(PLL_LOCK), .TX_RESETDONE(TX_RESETDONE),
    .SYNC_DONE(SYNC_DONE), .GTX_TXRESET(GTX_TXRESET), .SYNC_RST(SYNC_RST),
    .LINK_READY(LINK_READY), .RETRY_CNT(RETRY_CNT), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %-22s got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %-22s = %0d", tag, obs);
    end
  endtask

  function automatic logic [3:0] sig(input int which);
    case (which)
      SIG_TXRST:   return {3'b000, GTX_TXRESET};
      SIG_SYNCRST: return {3'b000, SYNC_RST};
      SIG_READY:   return {3'b000, LINK_READY};
      SIG_FAULT:   return {3'b000, FAULT};
      default:     return RETRY_CNT;
    endcase
  endfunction

  // Counts clock edges until the selected port reaches val, giving up after budget.
  task automatic wait_until(input int which, input logic [3:0] val, input int budget, output int n);
    n = 0;
    while (sig(which) != val && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pre;
    RST = 1'b0; PLL_LOCK = 1'b0; TX_RESETDONE = 1'b0; SYNC_DONE = 1'b0;
    #1 RST = 1'b1;
    #2;
    check("rst_gtx_txreset", GTX_TXRESET, 1);
    check("rst_sync_rst", SYNC_RST, 1);
    check("rst_link_ready", LINK_READY, 0);
    check("rst_fault", FAULT, 0);
    check("rst_retry", RETRY_CNT, 0);
    tick(3);
    RST = 1'b0;
    tick(3);
    check("idle_gtx_txreset", GTX_TXRESET, 1);

    // Nominal bring-up
    PLL_LOCK = 1'b1;
    wait_until(SIG_TXRST, 0, 100, n);
    check("nom_txreset_fall", n, BRINGUP);
    check("nom_sync_rst_held", SYNC_RST, 1);
    tick(10);
    TX_RESETDONE = 1'b1;
    wait_until(SIG_SYNCRST, 0, 100, n);
    check("nom_sync_rst_fall", n, 4);
    tick(50);
    SYNC_DONE = 1'b1;
    wait_until(SIG_READY, 1, 100, n);
    check("nom_link_ready", n, 1);
    check("nom_retry", RETRY_CNT, 0);

    // State upset in one copy while linked
    upset = dut.copy2_q;
    upset.state = S_FAULT;
    force dut.copy2_q = upset;
    tick(1);
    check("upset_link_ready", LINK_READY, 1);
    check("upset_fault", FAULT, 0);
    check("upset_txreset", GTX_TXRESET, 0);
    release dut.copy2_q;
    tick(1);
    check("upset_state2_fixed", 32'(dut.copy2_q.state), 32'(S_LINK_UP));
    check("upset_ready_after", LINK_READY, 1);

    // PLL loss in Link_Up, then full rerun
    PLL_LOCK = 1'b0;
    wait_until(SIG_READY, 0, 20, n);
    check("loss_ready_drop", n, 3);
    check("loss_txreset", GTX_TXRESET, 1);
    check("loss_sync_rst", SYNC_RST, 1);
    SYNC_DONE = 1'b0;
    TX_RESETDONE = 1'b0;
    tick(4);
    PLL_LOCK = 1'b1;
    wait_until(SIG_TXRST, 0, 100, n);
    check("rerun_txreset_fall", n, BRINGUP);
    TX_RESETDONE = 1'b1;
    wait_until(SIG_SYNCRST, 0, 100, n);
    check("rerun_sync_rst_fall", n, 4);
    SYNC_DONE = 1'b1;
    wait_until(SIG_READY, 1, 20, n);
    check("rerun_link_ready", n, 1);

    // Lock glitch at lcnt=5 restarts the lock wait
    PLL_LOCK = 1'b0;
    tick(3);
    SYNC_DONE = 1'b0;
    TX_RESETDONE = 1'b0;
    tick(4);
    check("glitch_pre_ready", LINK_READY, 0);
    PLL_LOCK = 1'b1;
    tick(7);
    PLL_LOCK = 1'b0;
    tick(1);
    PLL_LOCK = 1'b1;
    wait_until(SIG_TXRST, 0, 100, n);
    check("glitch_relock_wait", n, BRINGUP);

    // Sync timeouts, retries and fault
    TX_RESETDONE = 1'b1;
    wait_until(SIG_SYNCRST, 0, 100, n);
    check("to_sync_rst_fall", n, 4);
    for (int k = 1; k <= MR + 1; k++) begin
      pre = 0;
      if (k == 2) begin
        tick(20);
        upset = dut.copy1_q;
        upset.tcnt = upset.tcnt ^ 16'h0040;
        force dut.copy1_q = upset;
        tick(1);
        check("tupset_retry", RETRY_CNT, 1);
        check("tupset_sync_rst", SYNC_RST, 0);
        release dut.copy1_q;
        tick(1);
        check("tupset_tcnt1_fixed", dut.copy1_q.tcnt, 22);
        pre = 22;
      end
      if (k <= MR) wait_until(SIG_RETRY, 4'(k), 300, n);
      else wait_until(SIG_FAULT, 1, 300, n);
      check("to_timeout_cycles", pre + n, TO + 1);
      if (k <= MR) begin
        check("to_retry_txreset", GTX_TXRESET, 1);
        wait_until(SIG_TXRST, 0, 50, n);
        check("to_pulse_len", n, RP);
        wait_until(SIG_SYNCRST, 0, 50, n);
        check("to_sync_rst_fall2", n, 2);
      end
    end
    check("fault_retry", RETRY_CNT, MR);
    check("fault_txreset", GTX_TXRESET, 1);
    check("fault_sync_rst", SYNC_RST, 1);
    check("fault_ready", LINK_READY, 0);
    PLL_LOCK = 1'b0;
    tick(20);
    check("fault_sticky", FAULT, 1);
    check("fault_retry_hold", RETRY_CNT, MR);

    // RST clears the fault; then async reset in the middle of Wait_Sync
    RST = 1'b1;
    #1;
    check("rst_clears_fault", FAULT, 0);
    check("rst_clears_retry", RETRY_CNT, 0);
    tick(2);
    RST = 1'b0;
    PLL_LOCK = 1'b1;
    wait_until(SIG_SYNCRST, 0, 100, n);
    check("ar_reach_wait_sync", n, BRINGUP + 2);
    tick(5);
    check("ar_pre_txreset", GTX_TXRESET, 0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("ar_gtx_txreset", GTX_TXRESET, 1);
    check("ar_sync_rst", SYNC_RST, 1);
    check("ar_link_ready", LINK_READY, 0);
    check("ar_fault", FAULT, 0);
    check("ar_retry", RETRY_CNT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
